// File: rtl/i2c_poll_sequencer.sv
// Table-driven I2C polling sequencer: sweeps NUM_SLOTS programmable read/write entries
// through the shared I2C byte master. Define I2C_POLL_TIMEOUT_EN to build in the hung-bus watchdog.
module i2c_poll_sequencer #(
    parameter int  NUM_SLOTS      = 16,
    parameter int  I2C_DATA_WIDTH = 8,
    parameter int  REGISTER_WIDTH = 8,
    parameter int  ADDRESS_WIDTH  = 7,
    parameter int  POLL_GAP       = 1024,
    parameter int  TIMEOUT_CYCLES = 65535,
    localparam int IW             = $clog2(NUM_SLOTS),
    localparam int EW             = 2 + ADDRESS_WIDTH + REGISTER_WIDTH + I2C_DATA_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic                      cfg_we,
    input  logic [IW-1:0]             cfg_index,
    input  logic [EW-1:0]             cfg_entry,
    input  logic [IW-1:0]             rd_index,
    output logic [I2C_DATA_WIDTH-1:0] rd_data,
    output logic [NUM_SLOTS-1:0]      result_valid,
    output logic                      sweep_done,
    input  logic                      err_clr,
    output logic                      timeout_err,
    output logic [IW-1:0]             err_slot,
    input  logic                      i2c_busy,
    input  logic [I2C_DATA_WIDTH-1:0] i2c_miso_data,
    output logic                      i2c_enable,
    output logic                      i2c_read_write,
    output logic [I2C_DATA_WIDTH-1:0] i2c_mosi_data,
    output logic [REGISTER_WIDTH-1:0] i2c_register_address,
    output logic [ADDRESS_WIDTH-1:0]  i2c_device_address
);
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_ISSUE = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_NEXT  = 3'd4;
    localparam logic [2:0] ST_GAP   = 3'd5;

    localparam int DW = I2C_DATA_WIDTH;
    localparam int RW = REGISTER_WIDTH;
    localparam int AW = ADDRESS_WIDTH;
    localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

    localparam logic [IW:0]   SLOT_COUNT = (IW + 1)'(NUM_SLOTS);
    localparam logic [IW-1:0] LAST_SLOT  = IW'(NUM_SLOTS - 1);
    localparam logic [IW-1:0] SLOT_ONE   = IW'(1'b1);
    // POLL_GAP of 0 still spends the single GAP cycle
    localparam logic [GW-1:0] GAP_LAST   = GW'((POLL_GAP == 0) ? 0 : POLL_GAP - 1);
    localparam logic [GW-1:0] GAP_ONE    = GW'(1'b1);

    logic [EW-1:0]        table_r [NUM_SLOTS];
    logic [DW-1:0]        result_r [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] result_valid_r;
    logic [2:0]           state_r;
    logic [IW-1:0]        slot_r;
    logic [GW-1:0]        gap_cnt_r;
    logic [EW-1:0]        entry_s;
    logic                 tmo_hit_s;
    logic                 i2c_enable_r;
    logic                 i2c_read_write_r;
    logic [DW-1:0]        i2c_mosi_data_r;
    logic [RW-1:0]        i2c_register_address_r;
    logic [AW-1:0]        i2c_device_address_r;

    assign entry_s = table_r[slot_r];

    // Table programming from the BSP side, accepted in every state
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_SLOTS; i++) table_r[i] <= '0;
        end else if (cfg_we && ({1'b0, cfg_index} < SLOT_COUNT)) begin
            table_r[cfg_index] <= cfg_entry;
        end
    end

`ifdef I2C_POLL_TIMEOUT_EN
    localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES);

    logic [15:0]   tmo_cnt_r;
    logic          tmo_arm_s;
    logic          timeout_err_r;
    logic [IW-1:0] err_slot_r;

    // Only cycles that would otherwise keep waiting may expire the watchdog
    assign tmo_arm_s = ((state_r == ST_ISSUE) && !i2c_busy) || ((state_r == ST_WAIT) && i2c_busy);
    assign tmo_hit_s = tmo_arm_s && ((tmo_cnt_r + 16'd1) == TMO_LIMIT);

    // Per-transaction watchdog and sticky error capture; a new timeout beats err_clr
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_r     <= 16'd0;
            timeout_err_r <= 1'b0;
            err_slot_r    <= '0;
        end else begin
            if (state_r == ST_LOAD) begin
                tmo_cnt_r <= 16'd0;
            end else if ((state_r == ST_ISSUE) || (state_r == ST_WAIT)) begin
                tmo_cnt_r <= tmo_cnt_r + 16'd1;
            end
            if (tmo_hit_s) begin
                timeout_err_r <= 1'b1;
                err_slot_r    <= slot_r;
            end else if (err_clr) begin
                timeout_err_r <= 1'b0;
                err_slot_r    <= '0;
            end
        end
    end

    assign timeout_err = timeout_err_r;
    assign err_slot    = err_slot_r;
`else
    logic unused_s;

    assign unused_s    = err_clr;
    assign tmo_hit_s   = 1'b0;
    assign timeout_err = 1'b0;
    assign err_slot    = '0;
`endif

    // Sweep sequencing, bus request registers and read-result capture
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r                <= ST_IDLE;
            slot_r                 <= '0;
            gap_cnt_r              <= '0;
            i2c_enable_r           <= 1'b0;
            i2c_read_write_r       <= 1'b0;
            i2c_mosi_data_r        <= '0;
            i2c_register_address_r <= '0;
            i2c_device_address_r   <= '0;
            result_valid_r         <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) result_r[i] <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    slot_r <= '0;
                    if (enable && !i2c_busy) state_r <= ST_LOAD;
                end
                ST_LOAD: begin
                    if (entry_s[EW-1]) begin
                        i2c_read_write_r       <= entry_s[EW-2];
                        i2c_device_address_r   <= entry_s[DW+RW +: AW];
                        i2c_register_address_r <= entry_s[DW +: RW];
                        i2c_mosi_data_r        <= entry_s[DW-1:0];
                        i2c_enable_r           <= 1'b1;
                        state_r                <= ST_ISSUE;
                    end else begin
                        state_r <= ST_NEXT;
                    end
                end
                ST_ISSUE: begin
                    if (i2c_busy) begin
                        i2c_enable_r <= 1'b0;
                        state_r      <= ST_WAIT;
                    end else if (tmo_hit_s) begin
                        i2c_enable_r <= 1'b0;
                        state_r      <= ST_NEXT;
                    end
                end
                ST_WAIT: begin
                    if (!i2c_busy) begin
                        if (i2c_read_write_r) begin
                            result_r[slot_r]       <= i2c_miso_data;
                            result_valid_r[slot_r] <= 1'b1;
                        end
                        state_r <= ST_NEXT;
                    end else if (tmo_hit_s) begin
                        state_r <= ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    if (!enable) begin
                        state_r <= ST_IDLE;
                    end else if (slot_r == LAST_SLOT) begin
                        gap_cnt_r <= '0;
                        state_r   <= ST_GAP;
                    end else begin
                        slot_r  <= slot_r + SLOT_ONE;
                        state_r <= ST_LOAD;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_r == GAP_LAST) begin
                        state_r <= ST_IDLE;
                    end else begin
                        gap_cnt_r <= gap_cnt_r + GAP_ONE;
                    end
                end
                default: begin
                    i2c_enable_r <= 1'b0;
                    state_r      <= ST_IDLE;
                end
            endcase
        end
    end

    assign sweep_done           = (state_r == ST_NEXT) && enable && (slot_r == LAST_SLOT);
    assign rd_data              = result_r[rd_index];
    assign result_valid         = result_valid_r;
    assign i2c_enable           = i2c_enable_r;
    assign i2c_read_write       = i2c_read_write_r;
    assign i2c_mosi_data        = i2c_mosi_data_r;
    assign i2c_register_address = i2c_register_address_r;
    assign i2c_device_address   = i2c_device_address_r;

endmodule
